// File: rtl/fir_bank_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR filter bank.
package fir_bank_pkg;

   localparam int DEF_DW       = 16;
   localparam int DEF_CW       = 16;
   localparam int DEF_NTAP     = 16;
   localparam int DEF_NCH      = 4;
   localparam int DEF_APPROX_K = 4;

   // IDLE waits for a sample, MAC walks the taps of one channel, OUT presents it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Index width for n entries; never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Accumulator width: full product plus growth for summing ntap products.
   function automatic int acc_width(input int dw, input int cw, input int ntap);
      return dw + cw + $clog2(ntap);
   endfunction

endpackage

// File: rtl/fir_filter_bank_approx_mult.sv
// Signed DW x CW multiplier with an optional truncated-sample approximation.
// In approximate mode the sample operand is floored to a multiple of
// 2^APPROX_K before multiplying. Purely combinational.
module approx_mult #(
   parameter int DW       = 16,
   parameter int CW       = 16,
   parameter int APPROX_K = 4
) (
   input  logic signed [DW-1:0]    a,
   input  logic signed [CW-1:0]    b,
   input  logic                    approx,
   output logic signed [DW+CW-1:0] product
);

   // Clearing low bits of a two's-complement value floors it toward -inf.
   localparam logic [DW-1:0] KEEP_MASK = {DW{1'b1}} << APPROX_K;

   logic signed [DW-1:0]    w_a;
   logic signed [DW+CW-1:0] w_a_ext;
   logic signed [DW+CW-1:0] w_b_ext;

   // Operand selection and full-width signed multiply.
   always_comb begin
      w_a     = approx ? (a & KEEP_MASK) : a;
      w_a_ext = {{CW{w_a[DW-1]}}, w_a};
      w_b_ext = {{DW{b[CW-1]}}, b};
      product = w_a_ext * w_b_ext;
   end

endmodule

// File: rtl/fir_filter_bank.sv
// Time-multiplexed NCH-channel FIR bank: one shared delay line, per-channel
// coefficient sets, a single MAC walking NTAP taps per channel.
module fir_filter_bank
   import fir_bank_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int CW       = DEF_CW,
   parameter int NTAP     = DEF_NTAP,
   parameter int NCH      = DEF_NCH,
   parameter int APPROX_K = DEF_APPROX_K,
   parameter int AW       = acc_width(DW, CW, NTAP)
) (
   input  logic                          Clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [DW-1:0]          Xin,
   input  logic                          approx_en,
   input  logic                          cfg_we,
   input  logic [clog2_min1(NCH)-1:0]    cfg_ch,
   input  logic [clog2_min1(NTAP)-1:0]   cfg_tap,
   input  logic signed [CW-1:0]          cfg_data,
   output logic                          cfg_err,
   output logic                          out_valid,
   output logic [clog2_min1(NCH)-1:0]    out_ch,
   output logic signed [AW-1:0]          Yout
);

   localparam int CHW       = clog2_min1(NCH);
   localparam int TW        = clog2_min1(NTAP);
   localparam int CH_SLOTS  = 1 << CHW;
   localparam int TAP_SLOTS = 1 << TW;
   // Which index codes address a real channel / tap (matters for non-power-of-2 sizes).
   localparam logic [CH_SLOTS-1:0]  CH_OK  = {CH_SLOTS{1'b1}} >> (CH_SLOTS - NCH);
   localparam logic [TAP_SLOTS-1:0] TAP_OK = {TAP_SLOTS{1'b1}} >> (TAP_SLOTS - NTAP);

   state_t                  r_state;
   state_t                  w_next_state;
   logic signed [DW-1:0]    r_samples [NTAP];
   logic signed [CW-1:0]    r_coef    [NCH][NTAP];
   logic signed [AW-1:0]    r_acc;
   logic [CHW-1:0]          r_ch;
   logic [TW-1:0]           r_tap;
   logic                    r_mode;
   logic                    r_out_valid;
   logic [CHW-1:0]          r_out_ch;
   logic signed [AW-1:0]    r_yout;
   logic                    r_cfg_err;

   logic                    w_in_ready;
   logic                    w_accept;
   logic                    w_last_tap;
   logic                    w_last_ch;
   logic                    w_cfg_ok;
   logic signed [DW-1:0]    w_mul_a;
   logic signed [CW-1:0]    w_mul_b;
   logic signed [DW+CW-1:0] w_prod;
   logic signed [AW-1:0]    w_prod_ext;

   assign w_accept   = w_in_ready & in_valid;
   assign w_last_tap = (r_tap == TW'(NTAP - 1));
   assign w_last_ch  = (r_ch == CHW'(NCH - 1));
   assign w_cfg_ok   = CH_OK[cfg_ch] & TAP_OK[cfg_tap];
   assign w_mul_a    = r_samples[r_tap];
   assign w_mul_b    = r_coef[r_ch][r_tap];
   // Signed cast sign-extends the product into the accumulator width.
   assign w_prod_ext = AW'(w_prod);

   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_ch     = r_out_ch;
   assign Yout       = r_yout;
   assign cfg_err    = r_cfg_err;

   approx_mult #(
      .DW       (DW),
      .CW       (CW),
      .APPROX_K (APPROX_K)
   ) u_mult (
      .a       (w_mul_a),
      .b       (w_mul_b),
      .approx  (r_mode),
      .product (w_prod)
   );

   // State register.
   always_ff @(posedge Clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state logic and input handshake.
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) w_next_state = MAC;
         end
         MAC:     if (w_last_tap) w_next_state = OUT;
         OUT:     w_next_state = w_last_ch ? IDLE : MAC;
         default: w_next_state = IDLE;
      endcase
   end

   // Shared delay line: shift in a new sample on each acceptance.
   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         for (int k = 0; k < NTAP; k++) r_samples[k] <= '0;
      end else if (w_accept) begin
         for (int k = NTAP - 1; k > 0; k--) r_samples[k] <= r_samples[k-1];
         r_samples[0] <= Xin;
      end
   end

   // Coefficient store: writes only land while idle and in range; otherwise flag an error.
   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         for (int c = 0; c < NCH; c++)
            for (int t = 0; t < NTAP; t++) r_coef[c][t] <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg_we & ~((r_state == IDLE) & w_cfg_ok);
         if (cfg_we && (r_state == IDLE) && w_cfg_ok) r_coef[cfg_ch][cfg_tap] <= cfg_data;
      end
   end

   // MAC sequencing: accumulate one tap per cycle, restart per channel.
   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         r_acc  <= '0;
         r_ch   <= '0;
         r_tap  <= '0;
         r_mode <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mode <= approx_en;
                  r_ch   <= '0;
                  r_tap  <= '0;
                  r_acc  <= '0;
               end
            end
            MAC: begin
               r_acc <= r_acc + w_prod_ext;
               r_tap <= r_tap + 1'b1;
            end
            OUT: begin
               if (!w_last_ch) begin
                  r_ch  <= r_ch + 1'b1;
                  r_tap <= '0;
                  r_acc <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Output register: one-cycle result pulse per channel, presented after OUT.
   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_yout      <= '0;
      end else begin
         r_out_valid <= (r_state == OUT);
         if (r_state == OUT) begin
            r_out_ch <= r_ch;
            r_yout   <= r_acc;
         end
      end
   end

endmodule

// File: tb/tb_fir_filter_bank.sv
// Scoreboard bench for fir_filter_bank: a plain-arithmetic model predicts every
// channel result and its arrival cycle at acceptance; a monitor pops and compares.
module tb_fir_filter_bank;

   localparam int DW       = 16;
   localparam int CW       = 16;
   localparam int NTAP     = 16;
   localparam int NCH      = 4;
   localparam int APPROX_K = 4;
   localparam int AW       = DW + CW + $clog2(NTAP);
   localparam int CHW      = $clog2(NCH);
   localparam int TW       = $clog2(NTAP);
   localparam int SPACING  = NCH * (NTAP + 1) + 1;

   logic                 Clk;
   logic                 reset_n;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] Xin;
   logic                 approx_en;
   logic                 cfg_we;
   logic [CHW-1:0]       cfg_ch;
   logic [TW-1:0]        cfg_tap;
   logic signed [CW-1:0] cfg_data;
   logic                 cfg_err;
   logic                 out_valid;
   logic [CHW-1:0]       out_ch;
   logic signed [AW-1:0] Yout;

   fir_filter_bank #(
      .DW(DW), .CW(CW), .NTAP(NTAP), .NCH(NCH), .APPROX_K(APPROX_K), .AW(AW)
   ) dut (
      .Clk(Clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .Xin(Xin), .approx_en(approx_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_tap(cfg_tap), .cfg_data(cfg_data), .cfg_err(cfg_err),
      .out_valid(out_valid), .out_ch(out_ch), .Yout(Yout)
   );

   typedef struct {
      int     ch;
      longint y;
      longint due;
   } exp_t;

   exp_t   sb[$];
   longint m_delay [NTAP];
   longint m_coef  [NCH][NTAP];
   longint cyc = 0;
   longint last_acc = 0;
   int     checks = 0;
   int     passes = 0;
   logic signed [DW-1:0] rx;
   logic signed [CW-1:0] rc;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic void check(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Reference multiply: floor the sample to a multiple of 2^K in approximate mode.
   function automatic longint ref_mul(input longint x, input longint c, input bit ap);
      longint q;
      longint xf;
      q  = longint'(1) << APPROX_K;
      xf = x;
      if (ap) xf = x - (((x % q) + q) % q);
      return xf * c;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < NTAP; k++) m_delay[k] = 0;
      for (int c = 0; c < NCH; c++)
         for (int t = 0; t < NTAP; t++) m_coef[c][t] = 0;
   endfunction

   // Accepting a sample yields NCH dot products, each due 17 cycles after the previous.
   function automatic void model_accept(input longint x, input bit ap, input longint acc_cyc);
      for (int k = NTAP - 1; k > 0; k--) m_delay[k] = m_delay[k-1];
      m_delay[0] = x;
      for (int c = 0; c < NCH; c++) begin
         longint s;
         s = 0;
         for (int t = 0; t < NTAP; t++) s += ref_mul(m_delay[t], m_coef[c][t], ap);
         sb.push_back('{c, s, acc_cyc + longint'((c + 1) * (NTAP + 1))});
      end
   endfunction

   // Monitor: every out_valid must match the head of the scoreboard, value and timing.
   always @(negedge Clk) begin
      exp_t e;
      if (reset_n && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("out_ch", longint'(out_ch), longint'(e.ch));
            check("Yout", longint'(Yout), e.y);
            check("out_time", cyc, e.due);
         end
      end
   end

   task automatic send(input logic signed [DW-1:0] x, input bit ap);
      int waited;
      waited = 0;
      @(negedge Clk);
      Xin = x;
      approx_en = ap;
      in_valid = 1'b1;
      while (!in_ready && waited < 300) begin
         @(negedge Clk);
         waited++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         return;
      end
      last_acc = cyc + 1;
      model_accept(longint'(x), ap, cyc + 1);
      @(posedge Clk);
      #1;
      approx_en = ~ap;  // must be ignored until the next acceptance
   endtask

   task automatic stop_in();
      in_valid = 1'b0;
   endtask

   task automatic cfg_write(input int ch, input int tap, input logic signed [CW-1:0] d,
                            input bit expect_ok);
      @(negedge Clk);
      cfg_we   = 1'b1;
      cfg_ch   = CHW'(ch);
      cfg_tap  = TW'(tap);
      cfg_data = d;
      @(posedge Clk);
      if (expect_ok) m_coef[ch][tap] = longint'(d);
      @(negedge Clk);
      cfg_we = 1'b0;
      check(expect_ok ? "cfg_err_idle" : "cfg_err_busy", longint'(cfg_err), expect_ok ? 0 : 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", longint'(sb.size()), 0);
         sb.delete();
      end
      repeat (2) @(negedge Clk);
   endtask

   task automatic fill_coefs(input logic signed [CW-1:0] d);
      for (int c = 0; c < NCH; c++)
         for (int t = 0; t < NTAP; t++) cfg_write(c, t, d, 1'b1);
   endtask

   initial begin
      longint prev;
      reset_n = 1'b0; in_valid = 1'b0; Xin = '0; approx_en = 1'b0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_tap = '0; cfg_data = '0;
      model_clear();

      // Reset state
      repeat (3) @(negedge Clk);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_ch", longint'(out_ch), 0);
      check("rst_Yout", longint'(Yout), 0);
      check("rst_cfg_err", longint'(cfg_err), 0);
      reset_n = 1'b1;
      @(negedge Clk);
      check("rst_in_ready", longint'(in_ready), 1);

      // Impulse
      for (int t = 0; t < NTAP; t++) cfg_write(0, t, CW'(t + 1), 1'b1);
      for (int t = 0; t < NTAP; t++) cfg_write(1, t, -16'sd1, 1'b1);
      send(16'sd1, 1'b0);
      for (int i = 0; i < 15; i++) send(16'sd0, 1'b0);
      stop_in();
      wait_drain();

      // Full scale
      fill_coefs(16'sh7FFF);
      for (int i = 0; i < 18; i++) send(16'sh7FFF, 1'b0);
      stop_in();
      wait_drain();

      // Approximate mode
      fill_coefs(16'sd0);
      cfg_write(0, 0, 16'sd1, 1'b1);
      send(16'sd19, 1'b1);
      send(16'sd19, 1'b0);
      send(-16'sd19, 1'b1);
      stop_in();
      wait_drain();

      // Handshake: in_valid held high, acceptances spaced evenly
      send(16'sd3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         prev = last_acc;
         rx = DW'($urandom);
         send(rx, 1'b0);
         check("accept_spacing", last_acc - prev, SPACING);
      end
      stop_in();
      wait_drain();

      // Randomized coefficients, samples and modes
      for (int c = 0; c < NCH; c++)
         for (int t = 0; t < NTAP; t++) begin
            rc = CW'($urandom);
            cfg_write(c, t, rc, 1'b1);
         end
      for (int i = 0; i < 20; i++) begin
         rx = DW'($urandom);
         send(rx, 1'($urandom_range(0, 1)));
      end
      stop_in();
      wait_drain();

      // Config rules: busy write rejected, idle write applied, write+accept together
      send(16'sd100, 1'b0);
      stop_in();
      cfg_write(0, 0, 16'sd777, 1'b0);
      wait_drain();
      send(16'sd5, 1'b0);
      stop_in();
      wait_drain();
      cfg_write(0, 0, 16'sd777, 1'b1);
      send(16'sd7, 1'b0);
      stop_in();
      wait_drain();
      @(negedge Clk);
      cfg_we = 1'b1; cfg_ch = CHW'(1); cfg_tap = '0; cfg_data = -16'sd3;
      Xin = 16'sd9; approx_en = 1'b0; in_valid = 1'b1;
      m_coef[1][0] = -3;
      model_accept(9, 1'b0, cyc + 1);
      @(posedge Clk);
      #1;
      in_valid = 1'b0;
      @(negedge Clk);
      cfg_we = 1'b0;
      check("cfg_err_with_accept", longint'(cfg_err), 0);
      wait_drain();

      // Reset during channel 1 MAC aborts the sample
      send(16'sd50, 1'b0);
      stop_in();
      repeat (25) @(negedge Clk);
      reset_n = 1'b0;
      sb.delete();
      model_clear();
      repeat (2) @(negedge Clk);
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_Yout", longint'(Yout), 0);
      reset_n = 1'b1;
      @(negedge Clk);
      check("midrst_in_ready", longint'(in_ready), 1);
      repeat (80) @(negedge Clk);
      send(16'sd1, 1'b0);
      stop_in();
      wait_drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fir_filter_bank.md
Name: fir_filter_bank

Overview:
- Parametrised, time-multiplexed FIR filter bank for the hearing-aid channel split.
- One input sample stream drives NCH band filters. The filters share a single delay line, and each has its own NTAP coefficient set.
- A single MAC is reused across all taps and channels. Exact or approximate multiplication is selectable per sample.
- Replaces the single-channel fixed-tap FIR. Adds runtime coefficient loading and a valid/ready input handshake.

Parameters:
- DW, 16, input sample width (signed).
- CW, 16, coefficient width (signed).
- NTAP, 16, taps per channel.
- NCH, 4, number of band channels.
- APPROX_K, 4, number of sample LSBs zeroed in approximate mode.
- AW, DW+CW+$clog2(NTAP), accumulator/output width (signed).

Ports:
- Clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  Xin is valid.
- in_ready  out  1  block can accept a sample.
- Xin  in  DW  signed input sample.
- approx_en  in  1  approximate-multiply mode, sampled at acceptance.
- cfg_we  in  1  coefficient write strobe.
- cfg_ch  in  clog2(NCH)  coefficient channel index.
- cfg_tap  in  clog2(NTAP)  coefficient tap index.
- cfg_data  in  CW  signed coefficient value.
- cfg_err  out  1  one-cycle pulse: a write was rejected.
- out_valid  out  1  Yout/out_ch valid, single-cycle pulse.
- out_ch  out  clog2(NCH)  channel tag of Yout.
- Yout  out  AW  signed channel output.

Behaviour:
- Reset (reset_n low at a Clk edge):
  - State goes to IDLE; delay line, all coefficients and acc are cleared.
  - in_ready=1 from the first cycle after release; out_valid=0, out_ch=0, Yout=0, cfg_err=0.
  - A reset during MAC/OUT aborts the sample: no out_valid is produced for it.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: shift the delay line (sample[k]=sample[k-1], sample[0]=Xin).
  - Latch approx_en into mode_q; set ch=0, tap=0, acc=0; go to MAC.
- MAC:
  - in_ready=0.
  - Each cycle: acc += mult(sample[tap], coef[ch][tap]); tap++.
  - After the tap==NTAP-1 update, go to OUT.
  - NTAP cycles per channel.
- OUT:
  - Registered outputs: Yout=acc, out_ch=ch, out_valid=1 for exactly this one cycle.
  - If ch==NCH-1, go to IDLE. Otherwise ch++, tap=0, acc=0, go to MAC.
- Timing:
  - First out_valid occurs NTAP+1 cycles after the acceptance edge.
  - Outputs appear in channel order 0..NCH-1.
  - Accepted samples are spaced NCH*(NTAP+1)+1 cycles apart when in_valid is held high.
- No output backpressure; the downstream block must take Yout when out_valid=1.
- Multiply:
  - Exact mode: full signed DW×CW product.
  - Approximate mode (mode_q=1): sample operand has its low APPROX_K bits forced to 0 before multiplying, i.e. two's-complement floor to a multiple of 2^APPROX_K.
  - Product is sign-extended to AW. No overflow is possible; no saturation logic.
- Coefficient writes:
  - cfg_we in IDLE writes coef[cfg_ch][cfg_tap]=cfg_data at that edge. The new value is used from the next accepted sample.
  - cfg_we in MAC/OUT is ignored; cfg_err pulses high the next cycle.
  - If cfg_we and a sample acceptance occur on the same IDLE edge, both happen. The MAC uses the new coefficient.
  - Out-of-range cfg_ch (when NCH is not a power of 2) is ignored and pulses cfg_err.
- approx_en changes during MAC/OUT have no effect until the next acceptance.

Decomposition:
- Package fir_bank_pkg holds:
  - the state enum (IDLE/MAC/OUT);
  - a clog2 helper;
  - default widths;
  - the AW derivation.
- Sub-module approx_mult (params DW, CW, APPROX_K; inputs a, b, approx; output signed DW+CW product), purely combinational.
  - The next generation replaces it with other approximate multipliers without touching the FSM.
- Delay line, coefficient array and FSM stay in fir_filter_bank.

Test Plan:
1. Impulse:
   - Stimulus: ch0 coefs = 1..16, ch1 coefs all -1, ch2/ch3 zero, exact mode; Xin=1 followed by 15 zero samples.
   - Required: ch0 Yout sequence 1,2,...,16; ch1 Yout = -1 for the first 16 samples, then 0; ch2/ch3 always 0.
2. Full scale:
   - Stimulus: all coefs 0x7FFF, Xin held at 0x7FFF.
   - Required: from the 16th sample on, Yout = 17178820624 on every channel, with no wrap at AW=36.
3. Approximate mode:
   - Stimulus: coef[0][0]=1, other coefs 0; Xin=19.
   - Required: with approx_en=1, Yout=16; with approx_en=0, Yout=19; with Xin=-19 and approx_en=1, Yout=-32.
4. Handshake:
   - Stimulus: in_valid held high.
   - Required: in_ready high for 1 cycle in every 69; out_ch sequence 0,1,2,3 with out_valid at acceptance+17, +34, +51, +68.
5. Config rules:
   - Stimulus: cfg_we during MAC.
   - Required: cfg_err pulses and the coefficient is unchanged. The same write in IDLE takes effect on the next sample's output.
6. Reset mid-operation:
   - Stimulus: reset_n low during ch1 MAC.
   - Required: no further out_valid; in_ready=1 after release; next impulse response starts from a zeroed delay line with zeroed coefficients (Yout=0).
